// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter and its pickers.
package afifo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Index width that stays usable when only one or two entries exist.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle of the write arbiter.
// Handshake: a beat moves on a clock edge where valid and ready are both high; the
// source holds data/last stable while valid is high and ready is low.
interface afifo_wr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ-1:0]        o_req_ready;
   logic [N_REQ*DATA_W-1:0] i_req_data;
   logic [N_REQ-1:0]        i_req_last;
   logic                    o_fifo_valid;
   logic                    i_fifo_ready;
   logic [DATA_W-1:0]       o_fifo_data;

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_fifo_ready,
      output o_req_ready, o_fifo_valid, o_fifo_data
   );

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_fifo_ready,
      input  o_req_ready, o_fifo_valid, o_fifo_data
   );
endinterface

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
   import afifo_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = 0; i < N_REQ; i++) begin
         // Explicit modulo keeps the wrap correct for non power-of-two counts.
         cand = IDX_W'((int'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter feeding one async-FIFO write port.
module afifo_wr_arbiter
   import afifo_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int IDX_W     = clog2_min1(N_REQ)
) (
   input  logic               i_master_clk,
   input  logic               i_master_reset_n,
   afifo_wr_arbiter_if.slave  bus,
   output logic [IDX_W-1:0]   o_grant_id,
   output logic               o_busy,
   output arb_state_e         o_state
);

   localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;

   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_data;
   logic [N_REQ-1:0]  req_ready;

   logic [DATA_W-1:0] req_data [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign req_data[k] = bus.i_req_data[k*DATA_W +: DATA_W];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (bus.i_req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge i_master_clk or negedge i_master_reset_n) begin
      if (!i_master_reset_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      fifo_valid = 1'b0;
      fifo_data  = '0;
      req_ready  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ST_BURST;
            end
         end
         ST_BURST: begin
            // Grant stays locked even while the owner has nothing to send.
            fifo_valid         = bus.i_req_valid[grant_q];
            fifo_data          = req_data[grant_q];
            req_ready[grant_q] = bus.i_fifo_ready;
            if (fifo_valid && bus.i_fifo_ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (bus.i_req_last[grant_q] || (beat_cnt_q == LAST_BEAT)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_fifo_valid = fifo_valid;
   assign bus.o_fifo_data  = fifo_data;
   assign bus.o_req_ready  = req_ready;
   assign o_grant_id       = grant_q;
   assign o_busy           = (state_q == ST_BURST);
   assign o_state          = state_q;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter: burst timing, rotation, forced release, stalls, reset.
module tb_afifo_wr_arbiter;
   import afifo_pkg::*;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   afifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();
   logic [1:0] grant_id;
   logic       busy;
   arb_state_e state;

   afifo_wr_arbiter #(
      .N_REQ     (N_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .i_master_clk     (clk),
      .i_master_reset_n (rst_n),
      .bus              (bus),
      .o_grant_id       (grant_id),
      .o_busy           (busy),
      .o_state          (state)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- requester model ----------------
   logic [DATA_W-1:0] src_q      [N_REQ][$];
   logic              src_last_q [N_REQ][$];
   logic [DATA_W-1:0] exp_q      [N_REQ][$];
   logic [N_REQ-1:0]  en;
   int                acc_cyc [$];
   int                acc_id  [$];

   initial begin
      logic [N_REQ-1:0] fire;
      logic             in_rst;
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      bus.i_req_last  = '0;
      forever begin
         @(negedge clk);
         fire = bus.o_req_ready & bus.i_req_valid;
         @(posedge clk);
         in_rst = !rst_n;
         #2;
         for (int k = 0; k < N_REQ; k++) begin
            if (fire[k] && !in_rst && src_q[k].size() > 0) begin
               void'(src_q[k].pop_front());
               void'(src_last_q[k].pop_front());
            end
         end
         for (int k = 0; k < N_REQ; k++) begin
            bus.i_req_valid[k] = en[k] && (src_q[k].size() > 0);
            bus.i_req_data[k*DATA_W +: DATA_W] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
            bus.i_req_last[k] = (src_q[k].size() > 0) ? src_last_q[k][0] : 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial forever begin
      logic [DATA_W-1:0] exp_d;
      @(negedge clk);
      checks++;
      if (!$onehot0(bus.o_req_ready)) begin
         errors++;
         $display("FAIL ready_onehot0: got %b required at most one bit set", bus.o_req_ready);
      end
      if (bus.o_fifo_valid && bus.i_fifo_ready) begin
         acc_cyc.push_back(cyc);
         acc_id.push_back(int'(grant_id));
         checks++;
         if (exp_q[grant_id].size() == 0) begin
            errors++;
            $display("FAIL beat_data: got unexpected beat %h from req %0d, required none", bus.o_fifo_data, grant_id);
         end else begin
            exp_d = exp_q[grant_id].pop_front();
            if (bus.o_fifo_data !== exp_d) begin
               errors++;
               $display("FAIL beat_data: req %0d got %h required %h", grant_id, bus.o_fifo_data, exp_d);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // last_mode: 0 = never, 1 = final beat only, 2 = every beat
   task automatic push(input int k, input int n, input logic [7:0] tag, input int last_mode);
      logic [DATA_W-1:0] d;
      for (int b = 0; b < n; b++) begin
         d = {8'(k), tag, 16'(b)};
         src_q[k].push_back(d);
         src_last_q[k].push_back((last_mode == 2) || (last_mode == 1 && b == n - 1));
         exp_q[k].push_back(d);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      en = '1;
      bus.i_fifo_ready = 1'b1;
      for (int k = 0; k < N_REQ; k++) begin
         src_q[k].delete();
         src_last_q[k].delete();
         exp_q[k].delete();
      end
      acc_cyc.delete();
      acc_id.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic bit sb_empty();
      for (int k = 0; k < N_REQ; k++)
         if (exp_q[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input int max_cyc, output bit done);
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(negedge clk);
         done = sb_empty() && !busy;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      en = '1;
      bus.i_fifo_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.o_fifo_valid !== 1'b0 || bus.o_req_ready !== 4'b0 || bus.o_fifo_data !== '0 ||
          busy !== 1'b0 || grant_id !== 2'd0 || state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b ready=%b data=%h busy=%b grant=%0d required all 0",
                  bus.o_fifo_valid, bus.o_req_ready, bus.o_fifo_data, busy, grant_id);
      end
   endtask

   task automatic test_single_burst();
      int s;
      bit done;
      int e_cyc[$];
      apply_reset();
      s = cyc;
      push(0, 3, 8'h11, 1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.o_fifo_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_bubble: got busy=%b valid=%b required 0 0", busy, bus.o_fifo_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_last: got %b required 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL single_busy_fall: got busy=%b grant=%0d required 0 0", busy, grant_id);
      end
      wait_done(20, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL single_timeout: got not drained required drained");
      end
      for (int i = 0; i < 3; i++) e_cyc.push_back(s + 1 + i);
      checks++;
      if (acc_cyc.size() != 3) begin
         errors++;
         $display("FAIL single_count: got %0d beats required 3", acc_cyc.size());
      end
      for (int i = 0; i < e_cyc.size() && i < acc_cyc.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== 0) begin
            errors++;
            $display("FAIL single_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=0", i, acc_cyc[i], acc_id[i], e_cyc[i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int s;
      bit done;
      int e_cyc[$];
      int e_id[$];
      apply_reset();
      s = cyc;
      push(0, 2, 8'h22, 2);
      push(1, 2, 8'h22, 2);
      push(2, 1, 8'h22, 2);
      push(3, 1, 8'h22, 2);
      e_id = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) e_cyc.push_back(s + 1 + 2 * i);
      wait_done(40, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL rr_timeout: got not drained required drained");
      end
      checks++;
      if (acc_id.size() != e_id.size()) begin
         errors++;
         $display("FAIL rr_count: got %0d beats required %0d", acc_id.size(), e_id.size());
      end
      for (int i = 0; i < e_id.size() && i < acc_id.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== e_id[i]) begin
            errors++;
            $display("FAIL rr_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=%0d", i, acc_cyc[i], acc_id[i], e_cyc[i], e_id[i]);
         end
      end
   endtask

   task automatic test_forced_release();
      int s;
      bit done;
      int e_cyc[$];
      int e_id[$];
      apply_reset();
      s = cyc;
      push(1, 20, 8'h33, 1);
      push(2, 2, 8'h33, 1);
      for (int i = 0; i < 16; i++) begin e_cyc.push_back(s + 1 + i); e_id.push_back(1); end
      e_cyc.push_back(s + 18); e_id.push_back(2);
      e_cyc.push_back(s + 19); e_id.push_back(2);
      for (int i = 0; i < 4; i++) begin e_cyc.push_back(s + 21 + i); e_id.push_back(1); end
      wait_done(80, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL forced_timeout: got not drained required drained");
      end
      checks++;
      if (acc_id.size() != e_id.size()) begin
         errors++;
         $display("FAIL forced_count: got %0d beats required %0d", acc_id.size(), e_id.size());
      end
      for (int i = 0; i < e_id.size() && i < acc_id.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== e_id[i]) begin
            errors++;
            $display("FAIL forced_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=%0d", i, acc_cyc[i], acc_id[i], e_cyc[i], e_id[i]);
         end
      end
   endtask

   task automatic test_fifo_stall();
      int s;
      bit done;
      int e_cyc[$];
      apply_reset();
      s = cyc;
      push(0, 6, 8'h44, 1);
      wait_cyc(s + 3);
      bus.i_fifo_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.o_fifo_valid !== 1'b1 || bus.o_req_ready !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_cycle%0d: got valid=%b ready=%b busy=%b required 1 0000 1",
                     i, bus.o_fifo_valid, bus.o_req_ready, busy);
         end
      end
      @(posedge clk);
      #1 bus.i_fifo_ready = 1'b1;
      e_cyc = '{s + 1, s + 2, s + 8, s + 9, s + 10, s + 11};
      wait_done(40, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL stall_timeout: got not drained required drained");
      end
      checks++;
      if (acc_cyc.size() != 6) begin
         errors++;
         $display("FAIL stall_count: got %0d beats required 6", acc_cyc.size());
      end
      for (int i = 0; i < e_cyc.size() && i < acc_cyc.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== 0) begin
            errors++;
            $display("FAIL stall_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=0", i, acc_cyc[i], acc_id[i], e_cyc[i]);
         end
      end
   endtask

   task automatic test_valid_drop();
      int s;
      bit done;
      int e_cyc[$];
      int e_id[$];
      apply_reset();
      s = cyc;
      push(3, 5, 8'h55, 1);
      wait_cyc(s + 2);
      push(0, 1, 8'h55, 1);
      wait_cyc(s + 3);
      en[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.o_fifo_valid !== 1'b0 || bus.o_req_ready[0] !== 1'b0 || grant_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_cycle%0d: got valid=%b ready=%b grant=%0d busy=%b required 0 xxx0 3 1",
                     i, bus.o_fifo_valid, bus.o_req_ready, grant_id, busy);
         end
      end
      @(posedge clk);
      #1 en[3] = 1'b1;
      e_cyc = '{s + 1, s + 2, s + 7, s + 8, s + 9, s + 11};
      e_id  = '{3, 3, 3, 3, 3, 0};
      wait_done(40, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drop_timeout: got not drained required drained");
      end
      checks++;
      if (acc_id.size() != e_id.size()) begin
         errors++;
         $display("FAIL drop_count: got %0d beats required %0d", acc_id.size(), e_id.size());
      end
      for (int i = 0; i < e_id.size() && i < acc_id.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== e_id[i]) begin
            errors++;
            $display("FAIL drop_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=%0d", i, acc_cyc[i], acc_id[i], e_cyc[i], e_id[i]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int s;
      bit done;
      int e_cyc[$];
      int e_id[$];
      apply_reset();
      s = cyc;
      push(2, 4, 8'h66, 1);
      wait_cyc(s + 2);
      #2;
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd2) begin
         errors++;
         $display("FAIL pre_reset_grant: got busy=%b grant=%0d required 1 2", busy, grant_id);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_fifo_valid !== 1'b0 || bus.o_req_ready !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b ready=%b busy=%b grant=%0d required 0 0000 0 0",
                  bus.o_fifo_valid, bus.o_req_ready, busy, grant_id);
      end
      push(0, 1, 8'h66, 1);
      push(1, 1, 8'h66, 1);
      push(3, 1, 8'h66, 1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      e_cyc = '{s + 1, s + 4, s + 6, s + 8, s + 9, s + 10, s + 12};
      e_id  = '{2, 0, 1, 2, 2, 2, 3};
      wait_done(60, done);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL rst_timeout: got not drained required drained");
      end
      checks++;
      if (acc_id.size() != e_id.size()) begin
         errors++;
         $display("FAIL rst_count: got %0d beats required %0d", acc_id.size(), e_id.size());
      end
      for (int i = 0; i < e_id.size() && i < acc_id.size(); i++) begin
         checks++;
         if (acc_cyc[i] !== e_cyc[i] || acc_id[i] !== e_id[i]) begin
            errors++;
            $display("FAIL rst_beat%0d: got cyc=%0d id=%0d required cyc=%0d id=%0d", i, acc_cyc[i], acc_id[i], e_cyc[i], e_id[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_forced_release();
      test_fifo_stall();
      test_valid_drop();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
